// File: rtl/bank_cmd_scheduler.sv
// In-order DRAM command scheduler: open-row tracking, PRE/ACT/RD/WR sequencing.
// Optional SCHED_STATS_EN adds saturating hit/miss/conflict request counters.
module bank_cmd_scheduler #(
    parameter int CAS_LATENCY        = 22,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int BANK_GROUPS        = 2,
    parameter int BANKS_PER_GROUP    = 4,
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int PADDR_BITS         = 64,
    parameter int BURST_CYCLES       = 8
) (
    input  logic                               clk_in,
    input  logic                               rst_N_in,
    input  logic                               req_valid_in,
    output logic                               req_ready_out,
    input  logic [PADDR_BITS-1:0]              req_addr_in,
    input  logic                               req_write_in,
    input  logic [511:0]                       req_wdata_in,
    output logic                               valid_out,
    output logic [2:0]                         cmd_out,
    output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
    output logic [ROW_BITS-1:0]                row_out,
    output logic [COL_BITS-1:0]                col_out,
    output logic [511:0]                       val_out
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                        hit_count_out,
    output logic [31:0]                        miss_count_out,
    output logic [31:0]                        conflict_count_out
`endif
);

    localparam int BG_W     = $clog2(BANK_GROUPS);
    localparam int BA_W     = $clog2(BANKS_PER_GROUP);
    localparam int BI_W     = BG_W + BA_W;
    localparam int NBANK    = BANK_GROUPS * BANKS_PER_GROUP;
    localparam int BA_LO    = 3 + COL_BITS;
    localparam int BG_LO    = BA_LO + BA_W;
    localparam int ROW_LO   = BG_LO + BG_W;
    localparam int ADDR_TOP = ROW_LO + ROW_BITS;

    // Timers reload with latency-1 so the dependent command lands exactly L cycles later.
    localparam logic [15:0] PRE_LD = 16'(PRECHARGE_LATENCY - 1);
    localparam logic [15:0] ACT_LD = 16'(ACTIVATION_LATENCY - 1);
    localparam logic [15:0] RD_LD  = 16'(CAS_LATENCY + BURST_CYCLES - 1);
    localparam logic [15:0] WR_LD  = 16'(BURST_CYCLES - 1);

    if (CAS_LATENCY + BURST_CYCLES >= 65536 ||
        ACTIVATION_LATENCY + BURST_CYCLES >= 65536 ||
        PRECHARGE_LATENCY + BURST_CYCLES >= 65536 ||
        CAS_LATENCY < 1 || ACTIVATION_LATENCY < 1 ||
        PRECHARGE_LATENCY < 1 || BURST_CYCLES < 1) begin : g_bad_latency
        $error("bank_cmd_scheduler: latency out of range for 16-bit timers");
    end

    typedef enum logic [2:0] {
        CMD_RD  = 3'd0,
        CMD_WR  = 3'd1,
        CMD_ACT = 3'd2,
        CMD_PRE = 3'd3
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_PRE,
        S_WAIT_ACT,
        S_COLUMN
    } state_e;

    state_e              state;
    logic [15:0]         tmr;
    logic [15:0]         bus_tmr;
    logic [NBANK-1:0]    bank_open;
    logic [ROW_BITS-1:0] bank_row [NBANK];

    logic [COL_BITS-1:0] col_q;
    logic [BA_W-1:0]     ba_q;
    logic [BG_W-1:0]     bg_q;
    logic [ROW_BITS-1:0] row_q;
    logic                write_q;

    logic [BI_W-1:0]     bidx;
    logic                row_hit;
    logic                bus_free;
    logic                go;
    cmd_e                nxt_cmd;
    logic                unused_addr;

    assign unused_addr   = ^{req_addr_in[PADDR_BITS-1:ADDR_TOP], req_addr_in[2:0]};
    assign bidx          = {bg_q, ba_q};
    assign bus_free      = (bus_tmr == 16'd0);
    assign req_ready_out = (state == S_IDLE) && rst_N_in;

    // Pick the command this cycle may issue and whether its timing is satisfied.
    always_comb begin
        row_hit = bank_open[bidx] && (bank_row[bidx] == row_q);
        go      = 1'b0;
        nxt_cmd = write_q ? CMD_WR : CMD_RD;
        case (state)
            S_CHECK: begin
                if (row_hit) begin
                    go = bus_free;
                end else if (bank_open[bidx]) begin
                    go      = 1'b1;
                    nxt_cmd = CMD_PRE;
                end else begin
                    go      = 1'b1;
                    nxt_cmd = CMD_ACT;
                end
            end
            S_WAIT_PRE: begin
                go      = (tmr == 16'd0);
                nxt_cmd = CMD_ACT;
            end
            S_WAIT_ACT: go = (tmr == 16'd0) && bus_free;
            S_COLUMN:   go = bus_free;
            default:    go = 1'b0;
        endcase
    end

    // Sequencer FSM: request capture, bank table, timers and registered command strobe.
    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            state          <= S_IDLE;
            tmr            <= 16'd0;
            bus_tmr        <= 16'd0;
            bank_open      <= '0;
            col_q          <= '0;
            ba_q           <= '0;
            bg_q           <= '0;
            row_q          <= '0;
            write_q        <= 1'b0;
            valid_out      <= 1'b0;
            cmd_out        <= 3'd0;
            bank_group_out <= '0;
            bank_out       <= '0;
            row_out        <= '0;
            col_out        <= '0;
            val_out        <= '0;
        end else begin
            valid_out <= 1'b0;
            if (tmr != 16'd0) tmr <= tmr - 16'd1;
            if (bus_tmr != 16'd0) bus_tmr <= bus_tmr - 16'd1;

            if (go) begin
                valid_out      <= 1'b1;
                cmd_out        <= nxt_cmd;
                bank_group_out <= bg_q;
                bank_out       <= ba_q;
                row_out        <= row_q;
                col_out        <= col_q;
                case (nxt_cmd)
                    CMD_PRE: begin
                        bank_open[bidx] <= 1'b0;
                        tmr             <= PRE_LD;
                    end
                    CMD_ACT: begin
                        bank_open[bidx] <= 1'b1;
                        bank_row[bidx]  <= row_q;
                        tmr             <= ACT_LD;
                    end
                    CMD_WR:  bus_tmr <= WR_LD;
                    default: bus_tmr <= RD_LD;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (req_valid_in) begin
                        col_q   <= req_addr_in[3 +: COL_BITS];
                        ba_q    <= req_addr_in[BA_LO +: BA_W];
                        bg_q    <= req_addr_in[BG_LO +: BG_W];
                        row_q   <= req_addr_in[ROW_LO +: ROW_BITS];
                        write_q <= req_write_in;
                        val_out <= req_wdata_in;
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (row_hit)
                        state <= go ? S_IDLE : S_COLUMN;
                    else if (bank_open[bidx])
                        state <= S_WAIT_PRE;
                    else
                        state <= S_WAIT_ACT;
                end
                S_WAIT_PRE: if (go) state <= S_WAIT_ACT;
                S_WAIT_ACT: if (tmr == 16'd0) state <= go ? S_IDLE : S_COLUMN;
                S_COLUMN:   if (go) state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    // Classify each request once, in its CHECK cycle, into saturating counters.
    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            hit_count_out      <= 32'd0;
            miss_count_out     <= 32'd0;
            conflict_count_out <= 32'd0;
        end else if (state == S_CHECK) begin
            if (row_hit) begin
                if (hit_count_out != 32'hFFFF_FFFF)
                    hit_count_out <= hit_count_out + 32'd1;
            end else if (bank_open[bidx]) begin
                if (conflict_count_out != 32'hFFFF_FFFF)
                    conflict_count_out <= conflict_count_out + 32'd1;
            end else begin
                if (miss_count_out != 32'hFFFF_FFFF)
                    miss_count_out <= miss_count_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Scoreboard bench for bank_cmd_scheduler: directed requests push expected
// commands; a negedge monitor pops and compares every command strobe.
module tb_bank_cmd_scheduler;

    localparam logic [2:0] C_RD  = 3'd0;
    localparam logic [2:0] C_WR  = 3'd1;
    localparam logic [2:0] C_ACT = 3'd2;
    localparam logic [2:0] C_PRE = 3'd3;

    localparam int K_HIT  = 0;
    localparam int K_MISS = 1;
    localparam int K_CONF = 2;

    logic         clk_in = 1'b0;
    logic         rst_N_in = 1'b0;
    logic         req_valid_in = 1'b0;
    logic         req_ready_out;
    logic [63:0]  req_addr_in = '0;
    logic         req_write_in = 1'b0;
    logic [511:0] req_wdata_in = '0;
    logic         valid_out;
    logic [2:0]   cmd_out;
    logic         bank_group_out;
    logic [1:0]   bank_out;
    logic [7:0]   row_out;
    logic [3:0]   col_out;
    logic [511:0] val_out;
`ifdef SCHED_STATS_EN
    logic [31:0]  hit_count_out;
    logic [31:0]  miss_count_out;
    logic [31:0]  conflict_count_out;
`endif

    bank_cmd_scheduler dut (
        .clk_in         (clk_in),
        .rst_N_in       (rst_N_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_addr_in    (req_addr_in),
        .req_write_in   (req_write_in),
        .req_wdata_in   (req_wdata_in),
        .valid_out      (valid_out),
        .cmd_out        (cmd_out),
        .bank_group_out (bank_group_out),
        .bank_out       (bank_out),
        .row_out        (row_out),
        .col_out        (col_out),
        .val_out        (val_out)
`ifdef SCHED_STATS_EN
        ,
        .hit_count_out      (hit_count_out),
        .miss_count_out     (miss_count_out),
        .conflict_count_out (conflict_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]   cmd;
        logic         bg;
        logic [1:0]   ba;
        logic [7:0]   row;
        logic [3:0]   col;
        int           cyc;
        logic [511:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   bus_at = 0;
    int   a0, a1, a2, a3, a4, a5, a6, a7, a8;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected command.
    always @(negedge clk_in) begin
        if (valid_out) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_cmd got cmd=%0d bg=%0d ba=%0d row=%0h col=%0h issue_cyc=%0d, want none",
                         cmd_out, bank_group_out, bank_out, row_out, col_out, cyc - 1);
            end else begin
                mon_e = exp_q.pop_front();
                if (cmd_out !== mon_e.cmd || bank_group_out !== mon_e.bg ||
                    bank_out !== mon_e.ba || row_out !== mon_e.row ||
                    col_out !== mon_e.col || (cyc - 1) != mon_e.cyc) begin
                    n_bad++;
                    $display("FAIL cmd got cmd=%0d bg=%0d ba=%0d row=%0h col=%0h cyc=%0d, want cmd=%0d bg=%0d ba=%0d row=%0h col=%0h cyc=%0d",
                             cmd_out, bank_group_out, bank_out, row_out, col_out, cyc - 1,
                             mon_e.cmd, mon_e.bg, mon_e.ba, mon_e.row, mon_e.col, mon_e.cyc);
                end
                if (mon_e.cmd == C_WR) begin
                    n_cmp++;
                    if (val_out !== mon_e.data) begin
                        n_bad++;
                        $display("FAIL wdata got %h want %h", val_out, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [2:0] cmd, input logic bg, input logic [1:0] ba,
                        input logic [7:0] row, input logic [3:0] col, input int c,
                        input logic [511:0] data);
        exp_t e;
        e.cmd = cmd; e.bg = bg; e.ba = ba; e.row = row; e.col = col;
        e.cyc = c; e.data = data;
        exp_q.push_back(e);
    endtask

    function automatic logic [511:0] mkdata(input logic [63:0] mul, input logic [63:0] add);
        logic [511:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*64 +: 64] = 64'(k) * mul + add;
        return d;
    endfunction

    // Hold a request until accepted; a = cycle in which valid&&ready was high.
    task automatic send(input logic [63:0] addr, input logic wr, input logic [511:0] data,
                        output int a);
        a = -1;
        @(negedge clk_in);
        req_addr_in  = addr;
        req_write_in = wr;
        req_wdata_in = data;
        req_valid_in = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (req_ready_out) begin
                a = cyc;
                break;
            end
            @(negedge clk_in);
        end
        if (a < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout addr=%0h got no ready, want ready within 400 cycles", addr);
            req_valid_in = 1'b0;
            return;
        end
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
    endtask

    // Issue a request and queue the command sequence its class requires.
    task automatic req(input logic [63:0] addr, input logic wr, input logic [511:0] data,
                       input int kind, input logic bg, input logic [1:0] ba,
                       input logic [7:0] row, input logic [3:0] col,
                       input bit drop_col, output int a);
        int rdy;
        int cc;
        send(addr, wr, data, a);
        if (a < 0) return;
        if (kind == K_HIT) begin
            rdy = a + 1;
        end else if (kind == K_MISS) begin
            push(C_ACT, bg, ba, row, col, a + 1, data);
            rdy = a + 9;
        end else begin
            push(C_PRE, bg, ba, row, col, a + 1, data);
            push(C_ACT, bg, ba, row, col, a + 6, data);
            rdy = a + 14;
        end
        if (drop_col) return;
        cc = (rdy > bus_at) ? rdy : bus_at;
        push(wr ? C_WR : C_RD, bg, ba, row, col, cc, data);
        bus_at = cc + (wr ? 8 : 30);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk_in);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got %0d pending commands, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish, want finish before 1ms");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_in);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_ready", 64'(req_ready_out), 64'd0);
        check("rst_cmd", 64'(cmd_out), 64'd0);
        check("rst_fields", 64'({bank_group_out, bank_out, row_out, col_out}), 64'd0);
        check("rst_val", 64'(|val_out), 64'd0);
        rst_N_in = 1'b1;

        req(64'h0,   1'b0, '0, K_MISS, 1'b0, 2'd0, 8'd0, 4'd0, 1'b0, a0);
        req(64'h8,   1'b0, mkdata(64'h5, 64'h1), K_HIT, 1'b0, 2'd0, 8'd0, 4'd1, 1'b0, a1);
        check("ready_after_first_read", 64'(a1 - a0), 64'd10);
        req(64'h400, 1'b0, '0, K_CONF, 1'b0, 2'd0, 8'd1, 4'd0, 1'b0, a2);
        check("accept_after_hit_read", 64'(a2 - a0), 64'd40);
        req(64'h80,  1'b1, mkdata(64'h11, 64'h0), K_MISS, 1'b0, 2'd1, 8'd0, 4'd0, 1'b0, a3);
        check("accept_after_conflict", 64'(a3 - a0), 64'd70);
        req(64'h88,  1'b1, mkdata(64'h22, 64'h3), K_HIT, 1'b0, 2'd1, 8'd0, 4'd1, 1'b0, a4);
        req(64'h200, 1'b0, '0, K_MISS, 1'b1, 2'd0, 8'd0, 4'd0, 1'b0, a5);
        drain();
`ifdef SCHED_STATS_EN
        check("stat_hit", 64'(hit_count_out), 64'd2);
        check("stat_miss", 64'(miss_count_out), 64'd3);
        check("stat_conflict", 64'(conflict_count_out), 64'd1);
`endif

        req(64'h180, 1'b0, '0, K_MISS, 1'b0, 2'd3, 8'd0, 4'd0, 1'b1, a6);
        for (int n = 0; n < 20 && cyc < a6 + 4; n++) @(negedge clk_in);
        rst_N_in = 1'b0;
        #1;
        check("midrst_ready_low", 64'(req_ready_out), 64'd0);
        @(posedge clk_in);
        #1;
        check("midrst_valid", 64'(valid_out), 64'd0);
        check("midrst_ready_held", 64'(req_ready_out), 64'd0);
        @(negedge clk_in);
        rst_N_in = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready_out), 64'd1);
        bus_at = 0;

        req(64'h180, 1'b0, '0, K_MISS, 1'b0, 2'd3, 8'd0, 4'd0, 1'b0, a7);
        req(64'h0,   1'b0, '0, K_MISS, 1'b0, 2'd0, 8'd0, 4'd0, 1'b0, a8);
        drain();
        repeat (40) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
